// File: rtl/bluejay_line_streamer_pkg.sv
// Shared types and constants for the Bluejay line streamer.
//   state_e       : streamer FSM states
//   DEFAULT_*     : default geometry
//   pattern_word  : built-in test-pattern word (line_idx * words_per_line + word_idx)
package bluejay_line_streamer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLine,
        StSync,
        StData,
        StGap
    } state_e;

    localparam int unsigned DEFAULT_DATA_W          = 32;
    localparam int unsigned DEFAULT_WORDS_PER_LINE  = 40;
    localparam int unsigned DEFAULT_LINES_PER_FRAME = 1280;
    localparam int unsigned DEFAULT_LINE_GAP        = 2;

    // 64-bit result; callers truncate or zero-extend to the bus width, which gives mod 2^DATA_W.
    function automatic logic [63:0] pattern_word(input logic [31:0] line_idx,
                                                 input logic [31:0] word_idx,
                                                 input logic [31:0] words_per_line);
        return ({32'd0, line_idx} * {32'd0, words_per_line}) + {32'd0, word_idx};
    endfunction

endpackage

// File: rtl/bluejay_line_streamer_if.sv
// Bundle of FIFO-side inputs and Bluejay-bus outputs of the line streamer.
//   master : the streamer (reads FIFO status, drives bus/status outputs)
//   slave  : the surrounding system (FIFO + bus consumer)
interface bluejay_line_streamer_if
    import bluejay_line_streamer_pkg::*;
#(
    parameter int unsigned DATA_W          = DEFAULT_DATA_W,
    parameter int unsigned LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) ();

    localparam int unsigned LC_W = $clog2(LINES_PER_FRAME + 1);

    logic              buffer_switch_done;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_empty;
    logic              line_of_data_available;
    logic              dc32_fifo_almost_empty;
    logic              test_pattern_en;
    logic              get_next_word;
    logic [DATA_W-1:0] bluejay_data_out;
    logic              sync;
    logic              valid;
    logic [LC_W-1:0]   line_count;
    logic              frame_done;
    logic              busy;
    logic              underrun_err;

    modport master (
        input  buffer_switch_done, fifo_data_out, fifo_empty, line_of_data_available,
               dc32_fifo_almost_empty, test_pattern_en,
        output get_next_word, bluejay_data_out, sync, valid, line_count, frame_done, busy,
               underrun_err
    );

    modport slave (
        output buffer_switch_done, fifo_data_out, fifo_empty, line_of_data_available,
               dc32_fifo_almost_empty, test_pattern_en,
        input  get_next_word, bluejay_data_out, sync, valid, line_count, frame_done, busy,
               underrun_err
    );

endinterface

// File: rtl/bluejay_line_streamer_pattern_gen.sv
// Combinational test-pattern generator.
//   i_line_idx : lines completed so far in the frame
//   i_word_idx : word position within the current line
//   o_pattern  : (line_idx * WORDS_PER_LINE + word_idx) mod 2^DATA_W
module bluejay_line_streamer_pattern_gen
    import bluejay_line_streamer_pkg::*;
#(
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
    parameter int unsigned LC_W           = 11,
    parameter int unsigned WC_W           = 6
) (
    input  logic [LC_W-1:0]   i_line_idx,
    input  logic [WC_W-1:0]   i_word_idx,
    output logic [DATA_W-1:0] o_pattern
);

    assign o_pattern = DATA_W'(pattern_word(32'(i_line_idx), 32'(i_word_idx),
                                            32'(WORDS_PER_LINE)));

endmodule

// File: rtl/bluejay_line_streamer.sv
// Bluejay SLM line streamer: per line, one sync cycle then a contiguous burst of
// WORDS_PER_LINE valid words (FIFO data or test pattern), then LINE_GAP idle cycles.
//   fpga_clk : sole clock
//   reset_n  : asynchronous active-low reset
//   bus      : FIFO status/data in; get_next_word, data, sync, valid, line_count,
//              frame_done, busy, underrun_err out
module bluejay_line_streamer
    import bluejay_line_streamer_pkg::*;
#(
    parameter int unsigned DATA_W          = DEFAULT_DATA_W,
    parameter int unsigned WORDS_PER_LINE  = DEFAULT_WORDS_PER_LINE,
    parameter int unsigned LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME,
    parameter int unsigned LINE_GAP        = DEFAULT_LINE_GAP
) (
    input  logic                    fpga_clk,
    input  logic                    reset_n,
    bluejay_line_streamer_if.master bus
);

    localparam int unsigned LC_W = $clog2(LINES_PER_FRAME + 1);
    localparam int unsigned WC_W = $clog2(WORDS_PER_LINE + 1);
    localparam int unsigned GC_W = $clog2(LINE_GAP + 1);

    state_e            r_state, w_state_next;
    logic [WC_W-1:0]   r_word_idx, w_word_idx_next;
    logic [GC_W-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic [LC_W-1:0]   r_line_count, w_line_count_next;
    logic              r_tp, w_tp_next;
    logic              r_underrun, w_underrun_next;
    logic [DATA_W-1:0] r_data, w_data_next;
    logic              r_sync, w_sync_next;
    logic              r_valid, w_valid_next;
    logic              r_frame_done, w_frame_done_next;
    logic [DATA_W-1:0] w_pattern;

    bluejay_line_streamer_pattern_gen #(
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LC_W           (LC_W),
        .WC_W           (WC_W)
    ) u_pattern_gen (
        .i_line_idx (r_line_count),
        .i_word_idx (r_word_idx),
        .o_pattern  (w_pattern)
    );

    always_comb begin
        w_state_next      = r_state;
        w_word_idx_next   = r_word_idx;
        w_gap_cnt_next    = r_gap_cnt;
        w_line_count_next = r_line_count;
        w_tp_next         = r_tp;
        w_underrun_next   = r_underrun;
        w_data_next       = r_data;
        w_sync_next       = 1'b0;
        w_valid_next      = 1'b0;
        w_frame_done_next = 1'b0;

        unique case (r_state)
            StIdle: begin
                // The frame_done cycle is already IDLE; a start pulse there is dropped.
                if (bus.buffer_switch_done && !r_frame_done) begin
                    w_tp_next         = bus.test_pattern_en;
                    w_line_count_next = '0;
                    w_underrun_next   = 1'b0;
                    w_state_next      = StWaitLine;
                end
            end
            StWaitLine: begin
                if (r_tp || (bus.line_of_data_available && !bus.dc32_fifo_almost_empty)) begin
                    w_state_next = StSync;
                end
            end
            StSync: begin
                w_sync_next     = 1'b1;
                w_word_idx_next = '0;
                w_state_next    = StData;
            end
            StData: begin
                // Burst never stalls: an empty FIFO yields a zero word and flags underrun.
                w_valid_next = 1'b1;
                if (r_tp) begin
                    w_data_next = w_pattern;
                end else if (bus.fifo_empty) begin
                    w_data_next     = '0;
                    w_underrun_next = 1'b1;
                end else begin
                    w_data_next = bus.fifo_data_out;
                end
                if (r_word_idx == WC_W'(WORDS_PER_LINE - 1)) begin
                    w_word_idx_next = '0;
                    w_gap_cnt_next  = '0;
                    w_state_next    = StGap;
                end else begin
                    w_word_idx_next = r_word_idx + WC_W'(1);
                end
            end
            StGap: begin
                if (r_gap_cnt == GC_W'(LINE_GAP - 1)) begin
                    w_gap_cnt_next    = '0;
                    w_line_count_next = r_line_count + LC_W'(1);
                    if (r_line_count == LC_W'(LINES_PER_FRAME - 1)) begin
                        w_frame_done_next = 1'b1;
                        w_state_next      = StIdle;
                    end else begin
                        w_state_next = StWaitLine;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GC_W'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_word_idx   <= '0;
            r_gap_cnt    <= '0;
            r_line_count <= '0;
            r_tp         <= 1'b0;
            r_underrun   <= 1'b0;
            r_data       <= '0;
            r_sync       <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word_idx   <= w_word_idx_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_line_count <= w_line_count_next;
            r_tp         <= w_tp_next;
            r_underrun   <= w_underrun_next;
            r_data       <= w_data_next;
            r_sync       <= w_sync_next;
            r_valid      <= w_valid_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign bus.get_next_word    = (r_state == StData) && !r_tp && !bus.fifo_empty;
    assign bus.busy             = (r_state != StIdle);
    assign bus.bluejay_data_out = r_data;
    assign bus.sync             = r_sync;
    assign bus.valid            = r_valid;
    assign bus.line_count       = r_line_count;
    assign bus.frame_done       = r_frame_done;
    assign bus.underrun_err     = r_underrun;

endmodule

// File: tb/tb_bluejay_line_streamer.sv
// Scoreboard bench for bluejay_line_streamer with W=4, L=2, GAP=2, DATA_W=32.
module tb_bluejay_line_streamer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bluejay_line_streamer_if #(.DATA_W(32), .LINES_PER_FRAME(2)) bus ();

    bluejay_line_streamer #(
        .DATA_W          (32),
        .WORDS_PER_LINE  (4),
        .LINES_PER_FRAME (2),
        .LINE_GAP        (2)
    ) dut (
        .fpga_clk (clk),
        .reset_n  (reset_n),
        .bus      (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic force_empty = 1'b0;
    logic tp_mode = 1'b0;
    int sync_cnt = 0;
    int fd_cnt = 0;
    int gnw_tp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic update_fifo();
        bus.fifo_empty    = force_empty || (fifo_q.size() == 0);
        bus.fifo_data_out = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 32'(i));
            exp_q.push_back(base + 32'(i));
        end
        update_fifo();
    endtask

    task automatic clear_fifo();
        fifo_q.delete();
        update_fifo();
    endtask

    task automatic pulse_switch();
        @(negedge clk) bus.buffer_switch_done = 1'b1;
        @(negedge clk) bus.buffer_switch_done = 1'b0;
    endtask

    task automatic wait_sync(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.sync) seen = 1;
        end
        check(name, seen, 1);
    endtask

    // Optionally fires a start pulse in the very cycle frame_done is seen.
    task automatic wait_frame_done(input string name, input bit pulse_on_done);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
        end
        check(name, seen, 1);
        if (seen && pulse_on_done) begin
            bus.buffer_switch_done = 1'b1;
            @(negedge clk) bus.buffer_switch_done = 1'b0;
        end
    endtask

    // FIFO model: a read acked in a cycle advances the show-ahead head after that edge.
    initial begin
        logic gnw_s;
        forever begin
            @(negedge clk);
            #1 gnw_s = bus.get_next_word;
            @(posedge clk);
            #1;
            if (gnw_s) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                update_fifo();
            end
        end
    end

    // Monitor: pops the scoreboard on each valid word and checks framing.
    initial begin
        int run = 0;
        logic prev_sync = 1'b0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
                prev_sync = 1'b0;
            end else begin
                if (prev_sync) check("sync_then_valid", bus.valid, 1);
                if (bus.sync) begin
                    sync_cnt++;
                    check("sync_valid_excl", bus.valid, 0);
                end
                if (bus.frame_done) fd_cnt++;
                if (tp_mode && bus.get_next_word) gnw_tp_cnt++;
                if (bus.valid) begin
                    run++;
                    check("sb_has_entry", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("data", bus.bluejay_data_out, e);
                    end
                end else if (run != 0) begin
                    check("burst_len", run, 4);
                    run = 0;
                end
                prev_sync = bus.sync;
            end
        end
    end

    initial begin
        int sc0;
        int fd0;
        bus.buffer_switch_done     = 1'b0;
        bus.line_of_data_available = 1'b0;
        bus.dc32_fifo_almost_empty = 1'b0;
        bus.test_pattern_en        = 1'b0;
        update_fifo();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_flags", {bus.valid, bus.sync, bus.frame_done, bus.busy, bus.underrun_err,
                            bus.get_next_word}, 0);
        check("rst_data", bus.bluejay_data_out, 0);
        check("rst_line_count", bus.line_count, 0);
        reset_n = 1'b1;

        // 1: basic frame from FIFO
        load(32'hA0, 8);
        bus.line_of_data_available = 1'b1;
        pulse_switch();
        wait_frame_done("t1_frame_done", 0);
        check("t1_line_count", bus.line_count, 2);
        check("t1_underrun", bus.underrun_err, 0);
        @(negedge clk);
        check("t1_idle_after", {bus.busy, bus.frame_done}, 2'b00);

        // 2: start held off by missing line data
        clear_fifo();
        bus.line_of_data_available = 1'b0;
        load(32'hB0, 8);
        pulse_switch();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold", {bus.sync, bus.get_next_word, bus.busy}, 3'b001);
        end
        bus.line_of_data_available = 1'b1;
        @(negedge clk);
        check("t2_sync_not_yet", bus.sync, 0);
        @(negedge clk);
        check("t2_sync", bus.sync, 1);
        wait_frame_done("t2_frame_done", 0);
        check("t2_line_count", bus.line_count, 2);

        // 3: FIFO empty on word 2 of line 0
        clear_fifo();
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hC0 + 32'(i));
        update_fifo();
        exp_q.push_back(32'hC0);
        exp_q.push_back(32'hC1);
        exp_q.push_back(32'h0);
        for (int i = 2; i < 7; i++) exp_q.push_back(32'hC0 + 32'(i));
        pulse_switch();
        wait_sync("t3_sync");
        @(negedge clk);
        @(negedge clk);
        force_empty = 1'b1;
        update_fifo();
        #1 check("t3_no_read", bus.get_next_word, 0);
        @(negedge clk);
        force_empty = 1'b0;
        update_fifo();
        check("t3_underrun_set", bus.underrun_err, 1);
        wait_frame_done("t3_frame_done", 0);
        check("t3_underrun_sticky", bus.underrun_err, 1);

        // 4: test pattern, FIFO must not be touched
        clear_fifo();
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hEE);
        update_fifo();
        bus.line_of_data_available = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        check("t4_underrun_before", bus.underrun_err, 1);
        bus.test_pattern_en = 1'b1;
        tp_mode = 1'b1;
        pulse_switch();
        bus.test_pattern_en = 1'b0;
        wait_frame_done("t4_frame_done", 0);
        tp_mode = 1'b0;
        check("t4_gnw_count", gnw_tp_cnt, 0);
        check("t4_fifo_untouched", fifo_q.size(), 4);
        check("t4_underrun_cleared", bus.underrun_err, 0);

        // 5: async reset in DATA cycle 2, then restart
        clear_fifo();
        bus.line_of_data_available = 1'b1;
        load(32'hD0, 2);
        for (int i = 2; i < 8; i++) fifo_q.push_back(32'hD0 + 32'(i));
        update_fifo();
        pulse_switch();
        wait_sync("t5_sync");
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_flags", {bus.valid, bus.sync, bus.frame_done, bus.busy,
                               bus.underrun_err, bus.get_next_word}, 0);
        check("t5_rst_data", bus.bluejay_data_out, 0);
        check("t5_rst_line_count", bus.line_count, 0);
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("t5_idle", {bus.busy, bus.valid}, 2'b00);
        clear_fifo();
        load(32'hE0, 8);
        pulse_switch();
        wait_frame_done("t5_frame_done", 0);
        check("t5_line_count", bus.line_count, 2);

        // 6: start pulses mid-frame and on the frame_done cycle are ignored
        clear_fifo();
        load(32'hF0, 8);
        sc0 = sync_cnt;
        fd0 = fd_cnt;
        pulse_switch();
        repeat (8) @(negedge clk);
        pulse_switch();
        wait_frame_done("t6_frame_done", 1);
        repeat (20) @(negedge clk);
        check("t6_busy", bus.busy, 0);
        check("t6_sync_count", sync_cnt - sc0, 2);
        check("t6_fd_count", fd_cnt - fd0, 1);
        check("t6_line_count", bus.line_count, 2);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
